// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: final operand select, load-use hazard detection,
// bubble insertion on stall/flush, and a saturating count of load-use bubbles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_BUBBLE | EX register holds no instruction (reset, flush or bubble)
// ST_VALID  | EX register holds an accepted instruction
module idex_pipe_reg #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_raddr1,
   input  logic [4:0]       id_raddr2,
   input  logic             id_re1,
   input  logic             id_re2,
   input  logic [XLEN-1:0]  id_rdata1,
   input  logic [XLEN-1:0]  id_rdata2,
   input  logic             id_we,
   input  logic [4:0]       id_waddr,
   input  logic             id_load,
   input  logic [15:0]      id_ctrl,
   input  logic             fwd_a,
   input  logic             fwd_b,
   input  logic [XLEN-1:0]  fwd_asrc,
   input  logic [XLEN-1:0]  fwd_bsrc,
   input  logic             mem_we,
   input  logic             mem_load,
   input  logic [4:0]       mem_waddr,
   input  logic             flush,
   input  logic             ex_allowin,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_imm,
   output logic [XLEN-1:0]  ex_src1,
   output logic [XLEN-1:0]  ex_src2,
   output logic             ex_we,
   output logic             ex_load,
   output logic [4:0]       ex_waddr,
   output logic [15:0]      ex_ctrl,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic {
      ST_BUBBLE = 1'b0,
      ST_VALID  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  imm_q, imm_d;
   logic [XLEN-1:0]  src1_q, src1_d;
   logic [XLEN-1:0]  src2_q, src2_d;
   logic             we_q, we_d;
   logic             load_q, load_d;
   logic [4:0]       waddr_q, waddr_d;
   logic [15:0]      ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  sel_src1;
   logic [XLEN-1:0]  sel_src2;
   logic             ex_load_busy;
   logic             mem_load_busy;
   logic             dep1;
   logic             dep2;
   logic             hazard;
   logic             cnt_sat;

   // x0 reads as zero even if the forwarding network claims a hit on it
   always_comb begin
      if (id_raddr1 == 5'd0) begin
         sel_src1 = '0;
      end else if (fwd_a) begin
         sel_src1 = fwd_asrc;
      end else begin
         sel_src1 = id_rdata1;
      end
   end

   always_comb begin
      if (id_raddr2 == 5'd0) begin
         sel_src2 = '0;
      end else if (fwd_b) begin
         sel_src2 = fwd_bsrc;
      end else begin
         sel_src2 = id_rdata2;
      end
   end

   // Load results are not forwardable from EX or MEM, so either match stalls
   assign ex_load_busy  = (state_q == ST_VALID) && load_q && we_q;
   assign mem_load_busy = mem_load && mem_we;

   assign dep1 = id_re1 && (id_raddr1 != 5'd0) &&
                 ((ex_load_busy && (waddr_q == id_raddr1)) ||
                  (mem_load_busy && (mem_waddr == id_raddr1)));
   assign dep2 = id_re2 && (id_raddr2 != 5'd0) &&
                 ((ex_load_busy && (waddr_q == id_raddr2)) ||
                  (mem_load_busy && (mem_waddr == id_raddr2)));

   assign hazard   = id_valid && (dep1 || dep2);
   assign id_ready = ex_allowin && !hazard && !flush;
   assign cnt_sat  = (cnt_q == {CNT_W{1'b1}});

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      imm_d   = imm_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      we_d    = we_q;
      load_d  = load_q;
      waddr_d = waddr_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = ST_BUBBLE;
      end else if (ex_allowin) begin
         if (id_valid && !hazard) begin
            state_d = ST_VALID;
            pc_d    = id_pc;
            imm_d   = id_imm;
            src1_d  = sel_src1;
            src2_d  = sel_src2;
            we_d    = id_we;
            load_d  = id_load;
            waddr_d = id_waddr;
            ctrl_d  = id_ctrl;
         end else begin
            state_d = ST_BUBBLE;
            if (hazard && !cnt_sat) begin
               cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_BUBBLE;
         pc_q    <= '0;
         imm_q   <= '0;
         src1_q  <= '0;
         src2_q  <= '0;
         we_q    <= 1'b0;
         load_q  <= 1'b0;
         waddr_q <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         imm_q   <= imm_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         we_q    <= we_d;
         load_q  <= load_d;
         waddr_q <= waddr_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ex_valid  = (state_q == ST_VALID);
   assign ex_pc     = pc_q;
   assign ex_imm    = imm_q;
   assign ex_src1   = src1_q;
   assign ex_src2   = src2_q;
   assign ex_we     = ex_valid && we_q;
   assign ex_load   = ex_valid && load_q;
   assign ex_waddr  = waddr_q;
   assign ex_ctrl   = ctrl_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Scoreboard bench for idex_pipe_reg: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the EX register.
module tb_idex_pipe_reg;
   localparam int XLEN  = 64;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n, id_valid, id_ready, id_re1, id_re2, id_we, id_load;
   logic [XLEN-1:0]  id_pc, id_imm, id_rdata1, id_rdata2, fwd_asrc, fwd_bsrc;
   logic [4:0]       id_raddr1, id_raddr2, id_waddr, mem_waddr, ex_waddr;
   logic [15:0]      id_ctrl, ex_ctrl;
   logic             fwd_a, fwd_b, mem_we, mem_load, flush, ex_allowin;
   logic             ex_valid, ex_we, ex_load;
   logic [XLEN-1:0]  ex_pc, ex_imm, ex_src1, ex_src2;
   logic [CNT_W-1:0] stall_cnt;

   idex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_imm(id_imm), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
      .id_re1(id_re1), .id_re2(id_re2), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
      .id_we(id_we), .id_waddr(id_waddr), .id_load(id_load), .id_ctrl(id_ctrl),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_asrc(fwd_asrc), .fwd_bsrc(fwd_bsrc),
      .mem_we(mem_we), .mem_load(mem_load), .mem_waddr(mem_waddr), .flush(flush),
      .ex_allowin(ex_allowin), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_we(ex_we), .ex_load(ex_load),
      .ex_waddr(ex_waddr), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt)
   );

   typedef struct {
      bit               valid;
      bit               chk_data;
      logic [XLEN-1:0]  pc, imm, s1, s2;
      logic             we, load;
      logic [4:0]       waddr;
      logic [15:0]      ctrl;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model of what the EX register should hold
   bit               m_valid = 0;
   logic [XLEN-1:0]  m_pc = '0, m_imm = '0, m_s1 = '0, m_s2 = '0;
   logic             m_we = 0, m_load = 0;
   logic [4:0]       m_waddr = '0;
   logic [15:0]      m_ctrl = '0;
   logic [CNT_W-1:0] m_cnt = '0;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
   endtask

   function automatic bit dep(input logic re, input logic [4:0] ra);
      bit ex_hit, mem_hit;
      ex_hit  = m_valid && m_load && m_we && (m_waddr == ra);
      mem_hit = mem_load && mem_we && (mem_waddr == ra);
      return re && (ra != 5'd0) && (ex_hit || mem_hit);
   endfunction

   function automatic logic [XLEN-1:0] opsel(input logic [4:0] ra, input logic f,
                                             input logic [XLEN-1:0] fv, input logic [XLEN-1:0] rv);
      if (ra == 5'd0) return '0;
      return f ? fv : rv;
   endfunction

   task automatic model_step();
      bit   hz, rdy, was_rst;
      exp_t e;
      hz  = id_valid && (dep(id_re1, id_raddr1) || dep(id_re2, id_raddr2));
      rdy = ex_allowin && !hz && !flush;
      chk("id_ready", {63'd0, id_ready}, {63'd0, rdy});
      was_rst = !rst_n;
      if (!rst_n) begin
         m_valid = 0; m_pc = '0; m_imm = '0; m_s1 = '0; m_s2 = '0;
         m_we = 0; m_load = 0; m_waddr = '0; m_ctrl = '0; m_cnt = '0;
      end else if (flush) begin
         m_valid = 0;
      end else if (ex_allowin) begin
         if (id_valid && !hz) begin
            m_valid = 1; m_pc = id_pc; m_imm = id_imm;
            m_s1 = opsel(id_raddr1, fwd_a, fwd_asrc, id_rdata1);
            m_s2 = opsel(id_raddr2, fwd_b, fwd_bsrc, id_rdata2);
            m_we = id_we; m_load = id_load; m_waddr = id_waddr; m_ctrl = id_ctrl;
         end else begin
            m_valid = 0;
            if (hz && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
         end
      end
      e.valid = m_valid; e.chk_data = m_valid || was_rst;
      e.pc = m_pc; e.imm = m_imm; e.s1 = m_s1; e.s2 = m_s2;
      e.we = m_we; e.load = m_load; e.waddr = m_waddr; e.ctrl = m_ctrl; e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   // Monitor: compare the EX register just after each capturing edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.valid});
            chk("ex_we", {63'd0, ex_we}, {63'd0, e.valid && e.we});
            chk("ex_load", {63'd0, ex_load}, {63'd0, e.valid && e.load});
            chk("stall_cnt", {60'd0, stall_cnt}, {60'd0, e.cnt});
            if (e.chk_data) begin
               chk("ex_pc", ex_pc, e.pc);
               chk("ex_imm", ex_imm, e.imm);
               chk("ex_src1", ex_src1, e.s1);
               chk("ex_src2", ex_src2, e.s2);
               chk("ex_waddr", {59'd0, ex_waddr}, {59'd0, e.waddr});
               chk("ex_ctrl", {48'd0, ex_ctrl}, {48'd0, e.ctrl});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   task automatic idle();
      rst_n = 1; id_valid = 0; id_pc = '0; id_imm = '0;
      id_raddr1 = '0; id_raddr2 = '0; id_re1 = 0; id_re2 = 0;
      id_rdata1 = '0; id_rdata2 = '0; id_we = 0; id_waddr = '0; id_load = 0;
      id_ctrl = '0; fwd_a = 0; fwd_b = 0; fwd_asrc = '0; fwd_bsrc = '0;
      mem_we = 0; mem_load = 0; mem_waddr = '0; flush = 0; ex_allowin = 1;
   endtask

   task automatic tick();
      #1;
      model_step();
      @(negedge clk);
   endtask

   task automatic set_load_x5();
      idle(); id_valid = 1; id_load = 1; id_we = 1; id_waddr = 5'd5;
      id_pc = 64'h100; id_ctrl = 16'h0003;
   endtask

   // add x6, x5, x1
   task automatic set_add_x6();
      idle(); id_valid = 1; id_raddr1 = 5'd5; id_re1 = 1; id_raddr2 = 5'd1; id_re2 = 1;
      id_we = 1; id_waddr = 5'd6; id_pc = 64'h104; id_rdata1 = 64'h55; id_rdata2 = 64'h11;
      id_ctrl = 16'h0001;
   endtask

   task automatic rand_inputs();
      rst_n      = ($urandom_range(0, 99) != 0);
      id_valid   = ($urandom_range(0, 9) < 8);
      id_pc      = {$urandom, $urandom};
      id_imm     = {$urandom, $urandom};
      id_raddr1  = 5'($urandom_range(0, 3));
      id_raddr2  = 5'($urandom_range(0, 3));
      id_re1     = 1'($urandom);
      id_re2     = 1'($urandom);
      id_rdata1  = {$urandom, $urandom};
      id_rdata2  = {$urandom, $urandom};
      id_we      = ($urandom_range(0, 9) < 7);
      id_waddr   = 5'($urandom_range(0, 3));
      id_load    = ($urandom_range(0, 9) < 3);
      id_ctrl    = 16'($urandom);
      fwd_a      = 1'($urandom);
      fwd_b      = 1'($urandom);
      fwd_asrc   = {$urandom, $urandom};
      fwd_bsrc   = {$urandom, $urandom};
      mem_we     = 1'($urandom);
      mem_load   = ($urandom_range(0, 9) < 3);
      mem_waddr  = 5'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 19) == 0);
      ex_allowin = ($urandom_range(0, 9) < 8);
   endtask

   initial begin
      idle();
      rst_n = 0;
      @(negedge clk);
      tick();
      tick();
      chk("rst_valid", {63'd0, ex_valid}, 64'd0);
      chk("rst_cnt", {60'd0, stall_cnt}, 64'd0);

      // forwarding override and x0 suppression
      idle(); id_valid = 1; id_raddr1 = 5'd3; id_re1 = 1; fwd_a = 1;
      fwd_asrc = 64'h1234; id_rdata1 = 64'hdead; tick();
      chk("fwd_src1", ex_src1, 64'h1234);
      idle(); id_valid = 1; id_raddr1 = 5'd0; id_re1 = 1; fwd_a = 1;
      fwd_asrc = 64'h1234; id_rdata1 = 64'hdead; tick();
      chk("x0_src1", ex_src1, 64'd0);

      // load-use: one EX-match bubble, one MEM-match bubble, then accept
      set_load_x5(); tick();
      set_add_x6(); tick();
      chk("lu_bubble1", {63'd0, ex_valid}, 64'd0);
      set_add_x6(); mem_load = 1; mem_we = 1; mem_waddr = 5'd5; tick();
      chk("lu_bubble2", {63'd0, ex_valid}, 64'd0);
      set_add_x6(); tick();
      chk("lu_accept", {63'd0, ex_valid}, 64'd1);
      chk("lu_cnt", {60'd0, stall_cnt}, 64'd2);

      // dependency not actually read, and dependency on x0: no stall
      set_load_x5(); tick();
      set_add_x6(); id_re1 = 0; tick();
      chk("nore_accept", {63'd0, ex_valid}, 64'd1);
      set_load_x5(); id_waddr = 5'd0; tick();
      set_add_x6(); id_raddr1 = 5'd0; tick();
      chk("x0dep_accept", {63'd0, ex_valid}, 64'd1);
      chk("nostall_cnt", {60'd0, stall_cnt}, 64'd2);

      // EX back-pressure for 3 cycles, then release
      for (int i = 0; i < 3; i++) begin
         idle(); id_valid = 1; id_pc = 64'h200 + 64'(i); id_ex_rand();
         ex_allowin = 0; tick();
      end
      idle(); id_valid = 1; id_pc = 64'h300; tick();
      chk("release_pc", ex_pc, 64'h300);

      // flush kills EX; flush with hazard does not count a stall
      idle(); id_valid = 1; id_we = 1; flush = 1; tick();
      chk("flush_valid", {63'd0, ex_valid}, 64'd0);
      chk("flush_we", {63'd0, ex_we}, 64'd0);
      set_load_x5(); tick();
      set_add_x6(); flush = 1; tick();
      chk("flush_hz_cnt", {60'd0, stall_cnt}, 64'd2);

      // reach 7 stalls, then reset mid-stall
      for (int i = 0; i < 5; i++) begin
         set_add_x6(); mem_load = 1; mem_we = 1; mem_waddr = 5'd5; tick();
      end
      chk("cnt7", {60'd0, stall_cnt}, 64'd7);
      set_add_x6(); mem_load = 1; mem_we = 1; mem_waddr = 5'd5; rst_n = 0; tick();
      chk("midrst_valid", {63'd0, ex_valid}, 64'd0);
      chk("midrst_cnt", {60'd0, stall_cnt}, 64'd0);

      // saturation: drive to max-1 then two more bubbles
      for (int i = 0; i < 14; i++) begin
         set_add_x6(); mem_load = 1; mem_we = 1; mem_waddr = 5'd5; tick();
      end
      chk("cnt_max_m1", {60'd0, stall_cnt}, 64'd14);
      for (int i = 0; i < 2; i++) begin
         set_add_x6(); mem_load = 1; mem_we = 1; mem_waddr = 5'd5; tick();
      end
      chk("cnt_sat", {60'd0, stall_cnt}, 64'd15);

      idle(); rst_n = 0; tick();
      for (int i = 0; i < 3000; i++) begin
         rand_inputs(); tick();
      end

      idle(); tick();
      @(posedge clk);
      #2;
      if (sb.size() != 0) chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   task automatic id_ex_rand();
      id_imm = {$urandom, $urandom};
      id_rdata1 = {$urandom, $urandom};
      id_raddr1 = 5'd7;
      id_re1 = 1;
   endtask

endmodule

// File: doc/idex_pipe_reg.md
Name: idex_pipe_reg

Overview:
- ID/EX pipeline register of the 64-bit five-stage NPC core. Inputs are the decoded instruction and its register-file read data, plus the forwarding network's operand overrides.
- Selects the final EX operands and detects load-use hazards.
- On a hazard, stalls decode and inserts a bubble into EX.
- Registered outputs are the EX-stage state. They feed the ALU and return to the forwarding network as the ex_* hazard sources.

Parameters:
- XLEN, 64, datapath width.
- CNT_W, 32, width of the load-use stall counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_ready  out  1  decode may advance (combinational)
- id_pc  in  XLEN  instruction PC
- id_imm  in  XLEN  decoded immediate
- id_raddr1, id_raddr2  in  5  source register indices
- id_re1, id_re2  in  1  source register actually read
- id_rdata1, id_rdata2  in  XLEN  register-file read data
- id_we  in  1  instruction writes rd
- id_waddr  in  5  rd index
- id_load  in  1  instruction is a load
- id_ctrl  in  16  opaque ALU/mem control bundle
- fwd_a, fwd_b  in  1  forwarding hit for src1/src2
- fwd_asrc, fwd_bsrc  in  XLEN  forwarded values
- mem_we, mem_load  in  1  MEM-stage write and load flags, already valid-qualified
- mem_waddr  in  5  MEM-stage rd
- flush  in  1  branch/trap redirect, kills the instruction in decode and in EX
- ex_allowin  in  1  EX can accept a new instruction
- ex_valid  out  1  EX register holds a valid instruction
- ex_pc, ex_imm, ex_src1, ex_src2  out  XLEN  registered operands
- ex_we, ex_load  out  1  valid-qualified (0 when ex_valid=0)
- ex_waddr  out  5  rd index
- ex_ctrl  out  16  control bundle
- stall_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:

Reset (rst_n=0 at a clk edge):
- ex_valid=0, all ex_* data outputs=0, stall_cnt=0.
- Reset overrides every other input.

Operand select (combinational):
- src1 = 0 if id_raddr1==0; else fwd_asrc if fwd_a; else id_rdata1.
- src2 uses id_raddr2, fwd_b, fwd_bsrc and id_rdata2 the same way.

Hazard (combinational):
- Raised when id_valid and, for any source with re=1 and raddr!=0, either:
  - (ex_valid && ex_load_r && ex_we_r && ex_waddr==raddr), or
  - (mem_load && mem_we && mem_waddr==raddr).
- Loads are not forwarded from EX or MEM, so a load-use stall lasts up to 2 cycles.

Handshake:
- id_ready = ex_allowin && !hazard && !flush.
- A transfer occurs when id_valid && id_ready.

Clock-edge priority:
1. !rst_n → reset state.
2. flush → ex_valid=0; other registers don't-care, but ex_we/ex_load outputs read 0.
3. ex_allowin && id_valid && !hazard → capture pc, imm, src1, src2, we, waddr, load, ctrl; ex_valid=1.
4. ex_allowin && (hazard or !id_valid) → bubble: ex_valid=0.
5. !ex_allowin → hold all registers unchanged, including captured operands.

Counter:
- stall_cnt increments on every edge taking branch 4 with hazard=1.
- Saturates at all-ones; no wrap.

Latency and state:
- 1 cycle from accepted decode to EX outputs.
- No combinational path from id_* data to ex_* outputs.
- Two states per register: VALID and BUBBLE. No other state machine.

Test Plan:
- Back-to-back ALU ops with fwd_a=1, fwd_asrc=0x1234, id_rdata1=0xdead: ex_src1=0x1234 next cycle. With raddr1=0 and fwd_a=1, ex_src1=0.
- Load to x5 accepted, then `add x6,x5,x1` with id_re1=1: hazard → id_ready=0, ex_valid=0 for 1 cycle (mem_load match continues the stall for a 2nd cycle), then accepted. stall_cnt=2.
- Same dependency but id_re1=0, or dependency on x0: no stall, accepted in 1 cycle, stall_cnt unchanged.
- ex_allowin=0 for 3 cycles with ex_valid=1: all ex_* stable, id_ready=0. Then ex_allowin=1 → next instruction captured.
- flush asserted with id_valid=1, ex_valid=1: next cycle ex_valid=0, ex_we=0, id_ready=0 during flush. Flush plus hazard in the same cycle → flush wins, counter not incremented.
- rst_n=0 mid-stall with stall_cnt=7: next edge ex_valid=0 and stall_cnt=0. Force the counter to all-ones minus 1, apply 2 load-use bubbles → stall_cnt stays all-ones.
